// File: rtl/detector_pkg.sv
// Shared definitions for the detector event arbiter: default sizes,
// channel-index width helper and the output FSM state encoding.
package detector_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int DATA_W_DEF = 16;
  localparam int TIME_W_DEF = 64;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  localparam int CH_W_DEF = ch_width(NUM_CH_DEF);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the lowest-index requester
// found searching upward from last_grant+1, wrapping to channel 0.
module rr_picker
  import detector_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  localparam int CH_W  = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_grant,
  output logic [CH_W-1:0]   grant,
  output logic              any_req
);

  // Scan the requests in rotated order and keep the first hit.
  always_comb begin
    logic [CH_W-1:0] idx;
    // NOTE: every output gets a default before the loop so no path leaves
    // a value held from a previous evaluation, which would infer a latch.
    grant   = last_grant;
    any_req = 1'b0;
    idx     = '0;
    for (int off = 1; off <= NUM_CH; off++) begin
      idx = CH_W'((int'(last_grant) + off) % NUM_CH);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = idx;
      end
    end
  end

endmodule

// File: rtl/detector_event_arbiter.sv
// Detector event arbiter: one capture slot per channel, round-robin
// selection of pending slots onto a single valid/ready event output,
// and a saturating count of events lost to occupied slots.
module detector_event_arbiter
  import detector_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TIME_W = TIME_W_DEF,
  localparam int CH_W  = ch_width(NUM_CH)
) (
  input  logic                     clk210_p,
  input  logic                     reset_p,
  input  logic [NUM_CH-1:0]        ch_valid_p,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_p,
  input  logic [TIME_W-1:0]        timekeeper_time_p,
  input  logic                     timekeeper_ready_p,
  input  logic                     arb_enable_p,
  output logic                     evt_valid_p,
  input  logic                     evt_ready_p,
  output logic [CH_W-1:0]          evt_channel_p,
  output logic [DATA_W-1:0]        evt_data_p,
  output logic [TIME_W-1:0]        evt_time_p,
  output logic [NUM_CH-1:0]        pending_p,
  output logic [15:0]              drop_count_p
);

  arb_state_t        state;
  logic [NUM_CH-1:0] pending;
  logic [DATA_W-1:0] slot_data [NUM_CH];
  logic [TIME_W-1:0] slot_time [NUM_CH];
  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   grant_idx;
  logic              any_req;
  logic              grant_fire;
  logic [NUM_CH-1:0] grant_onehot;
  logic [NUM_CH-1:0] capture;
  logic [NUM_CH-1:0] drop;
  logic [16:0]       drop_sum;

  assign pending_p = pending;

  rr_picker #(.NUM_CH(NUM_CH)) u_rr_picker (
    .req        (pending),
    .last_grant (last_grant),
    .grant      (grant_idx),
    .any_req    (any_req)
  );

  // A grant happens from IDLE, or from PRESENT only on the handshake cycle.
  assign grant_fire = arb_enable_p && any_req &&
                      ((state == ST_IDLE) || evt_ready_p);

  // Per-channel capture/drop decisions; a slot being granted this cycle
  // counts as free so a pulse arriving on that cycle is kept.
  always_comb begin
    grant_onehot = '0;
    capture      = '0;
    drop         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      grant_onehot[i] = grant_fire && (grant_idx == CH_W'(i));
      capture[i] = ch_valid_p[i] && timekeeper_ready_p &&
                   (!pending[i] || grant_onehot[i]);
      drop[i]    = ch_valid_p[i] && timekeeper_ready_p &&
                   pending[i] && !grant_onehot[i];
    end
  end

  assign drop_sum = {1'b0, drop_count_p} + 17'($countones(drop));

  // Capture slots and their pending flags.
  always_ff @(posedge clk210_p or posedge reset_p) begin
    if (reset_p) begin
      pending <= '0;
      // NOTE: the slots are ordinary flops, not a RAM, so clearing them on
      // reset is cheap and keeps stale samples from ever being observable.
      for (int i = 0; i < NUM_CH; i++) begin
        slot_data[i] <= '0;
        slot_time[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (capture[i]) begin
          pending[i]   <= 1'b1;
          slot_data[i] <= ch_data_p[i*DATA_W +: DATA_W];
          slot_time[i] <= timekeeper_time_p;
        end else if (grant_onehot[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // Saturating count of events lost to an occupied slot.
  always_ff @(posedge clk210_p or posedge reset_p) begin
    if (reset_p) begin
      drop_count_p <= '0;
    end else if (drop_sum[16]) begin
      drop_count_p <= 16'hFFFF;
    end else begin
      drop_count_p <= drop_sum[15:0];
    end
  end

  // Output FSM: present one granted event at a time, back-to-back when
  // more slots are pending at the handshake.
  always_ff @(posedge clk210_p or posedge reset_p) begin
    if (reset_p) begin
      state         <= ST_IDLE;
      evt_valid_p   <= 1'b0;
      evt_channel_p <= '0;
      evt_data_p    <= '0;
      evt_time_p    <= '0;
      last_grant    <= CH_W'(NUM_CH - 1);
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values, independent of statement order.
      if (grant_fire) begin
        state         <= ST_PRESENT;
        evt_valid_p   <= 1'b1;
        evt_channel_p <= grant_idx;
        evt_data_p    <= slot_data[grant_idx];
        evt_time_p    <= slot_time[grant_idx];
        last_grant    <= grant_idx;
      end else begin
        case (state)
          ST_PRESENT: begin
            if (evt_ready_p) begin
              state       <= ST_IDLE;
              evt_valid_p <= 1'b0;
            end
          end
          default: begin
            state       <= ST_IDLE;
            evt_valid_p <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_detector_event_arbiter.sv
// Directed self-checking bench for detector_event_arbiter (4 channels,
// 16-bit samples, 64-bit time). Inputs change 1 time unit after a rising
// edge; outputs are checked at that same point, away from the edge.
module tb_detector_event_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  ch_valid;
  logic [63:0] ch_data;
  logic [63:0] tk_time;
  logic        tk_ready;
  logic        arb_en;
  logic        evt_valid;
  logic        evt_ready;
  logic [1:0]  evt_channel;
  logic [15:0] evt_data;
  logic [63:0] evt_time;
  logic [3:0]  pending;
  logic [15:0] drop_count;

  int total = 0;
  int bad   = 0;

  detector_event_arbiter dut (
    .clk210_p           (clk),
    .reset_p            (rst),
    .ch_valid_p         (ch_valid),
    .ch_data_p          (ch_data),
    .timekeeper_time_p  (tk_time),
    .timekeeper_ready_p (tk_ready),
    .arb_enable_p       (arb_en),
    .evt_valid_p        (evt_valid),
    .evt_ready_p        (evt_ready),
    .evt_channel_p      (evt_channel),
    .evt_data_p         (evt_data),
    .evt_time_p         (evt_time),
    .pending_p          (pending),
    .drop_count_p       (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [15:0] val);
    ch_data[ch*16 +: 16] = val;
  endtask

  task automatic check_evt(input string tag, input logic [1:0] ch,
                           input logic [15:0] d, input logic [63:0] t);
    check({tag, "_valid"}, 64'(evt_valid), 64'd1);
    check({tag, "_chan"},  64'(evt_channel), 64'(ch));
    check({tag, "_data"},  64'(evt_data), 64'(d));
    check({tag, "_time"},  evt_time, t);
  endtask

  initial begin
    rst       = 1'b1;
    ch_valid  = '0;
    ch_data   = '0;
    tk_time   = '0;
    tk_ready  = 1'b1;
    arb_en    = 1'b1;
    evt_ready = 1'b1;

    // Reset state
    #12;
    check("rst_valid",   64'(evt_valid), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_drop",    64'(drop_count), 64'd0);
    check("rst_chan",    64'(evt_channel), 64'd0);
    step();
    rst = 1'b0;

    // Four simultaneous pulses: captured together, delivered 0,1,2,3 with no bubbles
    ch_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_ch(i, 16'h00A0 + 16'(i));
    tk_time = 64'd200;
    step();
    ch_valid = '0;
    check("all4_pending", 64'(pending), 64'hF);
    check("all4_idle",    64'(evt_valid), 64'd0);
    step();
    check_evt("all4_ev0", 2'd0, 16'h00A0, 64'd200);
    check("all4_pend0", 64'(pending), 64'hE);
    step();
    check_evt("all4_ev1", 2'd1, 16'h00A1, 64'd200);
    step();
    check_evt("all4_ev2", 2'd2, 16'h00A2, 64'd200);
    step();
    check_evt("all4_ev3", 2'd3, 16'h00A3, 64'd200);
    check("all4_pend3", 64'(pending), 64'h0);
    step();
    check("all4_done", 64'(evt_valid), 64'd0);
    check("all4_drop", 64'(drop_count), 64'd0);

    // Single pulse on ch1: event valid after two edges
    ch_valid = 4'b0010;
    set_ch(1, 16'h1388);
    tk_time = 64'd100;
    step();
    ch_valid = '0;
    check("single_e1_valid", 64'(evt_valid), 64'd0);
    check("single_e1_pend",  64'(pending), 64'h2);
    step();
    check_evt("single", 2'd1, 16'h1388, 64'd100);
    step();
    check("single_done", 64'(evt_valid), 64'd0);

    // Timestamp not ready: pulse ignored, not a drop
    tk_ready = 1'b0;
    ch_valid = 4'b1000;
    set_ch(3, 16'h0BAD);
    tk_time = 64'd300;
    step();
    ch_valid = '0;
    tk_ready = 1'b1;
    check("tknr_pend", 64'(pending), 64'h0);
    check("tknr_drop", 64'(drop_count), 64'd0);
    step();
    check("tknr_valid", 64'(evt_valid), 64'd0);

    // Second pulse on ch2 while its slot is pending is dropped
    arb_en    = 1'b0;
    evt_ready = 1'b0;
    ch_valid  = 4'b0100;
    set_ch(2, 16'h0100);
    tk_time = 64'd400;
    step();
    check("drop_pend1", 64'(pending), 64'h4);
    set_ch(2, 16'h0200);
    tk_time = 64'd401;
    step();
    ch_valid = '0;
    check("drop_count1", 64'(drop_count), 64'd1);
    check("drop_pend2",  64'(pending), 64'h4);
    check("drop_held",   64'(evt_valid), 64'd0);
    arb_en = 1'b1;
    step();
    check_evt("drop_ev", 2'd2, 16'h0100, 64'd400);
    evt_ready = 1'b1;
    step();
    check("drop_done",   64'(evt_valid), 64'd0);
    check("drop_count2", 64'(drop_count), 64'd1);

    // Round robin after ch0 grant, and recapture on ch0's grant cycle
    evt_ready = 1'b0;
    ch_valid  = 4'b0001;
    set_ch(0, 16'h0011);
    tk_time = 64'd500;
    step();
    ch_valid = '0;
    step();
    check_evt("rr_ch0", 2'd0, 16'h0011, 64'd500);
    ch_valid = 4'b0011;
    set_ch(0, 16'h0022);
    set_ch(1, 16'h0033);
    tk_time = 64'd501;
    step();
    ch_valid = '0;
    check("rr_pend", 64'(pending), 64'h3);
    check("rr_stable_data", 64'(evt_data), 64'h0011);
    evt_ready = 1'b1;
    step();
    check_evt("rr_ch1", 2'd1, 16'h0033, 64'd501);
    check("rr_pend_b", 64'(pending), 64'h1);
    ch_valid = 4'b0001;
    set_ch(0, 16'h0044);
    tk_time = 64'd502;
    step();
    ch_valid = '0;
    check_evt("rr_ch0b", 2'd0, 16'h0022, 64'd501);
    check("rr_recap_pend", 64'(pending), 64'h1);
    check("rr_recap_drop", 64'(drop_count), 64'd1);
    step();
    check_evt("rr_ch0c", 2'd0, 16'h0044, 64'd502);
    check("rr_pend_c", 64'(pending), 64'h0);
    step();
    check("rr_done", 64'(evt_valid), 64'd0);

    // Reset mid-handshake with a slot still pending
    evt_ready = 1'b0;
    ch_valid  = 4'b1100;
    set_ch(2, 16'h0077);
    set_ch(3, 16'h0088);
    tk_time = 64'd550;
    step();
    ch_valid = '0;
    step();
    check_evt("mid_pres", 2'd2, 16'h0077, 64'd550);
    check("mid_pend", 64'(pending), 64'h8);
    rst = 1'b1;
    #1;
    check("mrst_valid", 64'(evt_valid), 64'd0);
    check("mrst_chan",  64'(evt_channel), 64'd0);
    check("mrst_data",  64'(evt_data), 64'd0);
    check("mrst_time",  evt_time, 64'd0);
    check("mrst_pend",  64'(pending), 64'd0);
    check("mrst_drop",  64'(drop_count), 64'd0);
    step();
    rst       = 1'b0;
    evt_ready = 1'b1;
    ch_valid  = 4'b1001;
    set_ch(0, 16'h0055);
    set_ch(3, 16'h0066);
    tk_time = 64'd600;
    step();
    ch_valid = '0;
    check("post_pend",  64'(pending), 64'h9);
    check("post_idle",  64'(evt_valid), 64'd0);
    step();
    check_evt("post_ch0", 2'd0, 16'h0055, 64'd600);
    step();
    check_evt("post_ch3", 2'd3, 16'h0066, 64'd600);
    check("post_drop", 64'(drop_count), 64'd0);
    step();
    check("post_done", 64'(evt_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/detector_event_arbiter.md
DETECTOR_EVENT_ARBITER -- requirements
Module: detector_event_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4, number of detector channels sharing the event output.
REQ-002 Parameter DATA_W, default 16, ADC sample width.
REQ-003 Parameter TIME_W, default 64, timekeeper timestamp width.
REQ-004 clk210_p  in  1  210 MHz system clock; the block's single clock.
REQ-005 reset_p  in  1  asynchronous, active-high reset.
REQ-006 ch_valid_p  in  NUM_CH  one-cycle event pulse per channel (threshold crossing).
REQ-007 ch_data_p  in  NUM_CH*DATA_W  per-channel sample; slice i belongs to channel i, valid with ch_valid_p[i].
REQ-008 timekeeper_time_p  in  TIME_W  current time.
REQ-009 timekeeper_ready_p  in  1  timestamp valid.
REQ-010 arb_enable_p  in  1  permits new grants.
REQ-011 evt_valid_p  out  1  output event valid.
REQ-012 evt_ready_p  in  1  downstream accepts event.
REQ-013 evt_channel_p  out  clog2(NUM_CH)  source channel of presented event.
REQ-014 evt_data_p  out  DATA_W  sample of presented event.
REQ-015 evt_time_p  out  TIME_W  capture timestamp of presented event.
REQ-016 pending_p  out  NUM_CH  per-channel slot-occupied flags.
REQ-017 drop_count_p  out  16  total dropped events, saturating.

Function
REQ-018 The block SHALL hold one capture slot per channel (data, timestamp, pending bit).
REQ-019 ch_valid_p[i]=1 with timekeeper_ready_p=1 and slot i free SHALL load ch_data_p slice i and timekeeper_time_p into slot i and set pending[i] at the next edge.
REQ-020 ch_valid_p[i] while timekeeper_ready_p=0 SHALL be ignored and not counted as a drop.
REQ-021 ch_valid_p[i] while pending[i]=1 and slot i not granted that cycle SHALL be dropped, slot i unchanged, drop_count_p incremented by 1 (saturating at 0xFFFF; multiple simultaneous drops add their count, saturating).
REQ-022 ch_valid_p[i] in the cycle slot i is granted SHALL be captured, pending[i] staying 1, no drop.
REQ-023 Simultaneous pulses on several channels SHALL all be captured into their own slots.
REQ-024 FSM states: IDLE (evt_valid_p=0) and PRESENT (evt_valid_p=1).
REQ-025 IDLE: if arb_enable_p=1 and any pending bit set, grant per REQ-027, load output registers, clear that pending bit, go to PRESENT.
REQ-026 PRESENT: outputs SHALL stay stable while evt_ready_p=0; on evt_valid_p&evt_ready_p, if arb_enable_p=1 and any pending bit set, load next grant back-to-back and stay in PRESENT, else go to IDLE.
REQ-027 Grant SHALL be round-robin: lowest-index pending channel searching upward from last_grant+1, wrapping NUM_CH-1 to 0; last_grant updates on each grant.
REQ-028 Latency: ch_valid_p at edge N into an idle block -> evt_valid_p high after edge N+2.
REQ-029 arb_enable_p=0 SHALL block new grants only; the presented event completes its handshake, captures continue.

Reset
REQ-030 reset_p=1 SHALL asynchronously clear pending bits, slots, drop_count_p, evt_valid_p, evt_channel_p, evt_data_p, evt_time_p to 0, state to IDLE, last_grant to NUM_CH-1 (channel 0 first).
REQ-031 Reset mid-handshake SHALL discard presented and pending events; nothing is counted as dropped.

Structure
REQ-032 Shared package detector_pkg SHALL hold NUM_CH, DATA_W, TIME_W defaults, channel-index width and FSM state encoding.
REQ-033 Round-robin selection SHALL be a combinational sub-module rr_picker (inputs request vector, last_grant; outputs grant index, any_req).

Verification
REQ-034 Single pulse ch1 data 0x1388 at time 100, ready held 1 -> evt_valid_p after 2 edges, channel 1, data 0x1388, time 100.
REQ-035 Pulses on ch0..ch3 same cycle, evt_ready_p=1 -> four back-to-back events, channel order 0,1,2,3, no bubbles, drop_count_p=0.
REQ-036 evt_ready_p=0, ch2 pulsed twice (0x0100 then 0x0200) while its slot pending -> drop_count_p=1, later delivered ch2 data 0x0100 only.
REQ-037 timekeeper_ready_p=0 during ch3 pulse -> no event, pending_p=0, drop_count_p=0.
REQ-038 Grant ch0 then ch0 and ch1 pending -> ch1 granted before ch0; ch0 re-pulsed on its grant cycle -> captured, no drop.
REQ-039 Assert reset_p while evt_valid_p=1 and slots pending -> all outputs 0 immediately, after release next grant starts at ch0.
